// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared definitions for the counter library: run-control
//                state encoding and the default counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnt_pkg;

    // Default width of the loadable counters in this library.
    localparam int CNT_WIDTH = 4;

    // Run-control states of the down-counter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cnt_state_e;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/cnt_down4_dp.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_down4_dp
//  Description : Datapath of the loadable down-counter. Holds the count and
//                reload registers, performs the decrement, and reports
//                zero/one detection of the count and zero of the reload value.
//  Ports       : clk, reset (async active-low)
//                load_ext/load_val - parallel load of count and reload
//                load_rel          - copy reload register into count
//                dec               - decrement count by one
//                count             - current count value
//                is_zero/is_one    - count equals 0 / 1
//                rel_zero          - reload register equals 0
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_down4_dp
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_ext,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_rel,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero,
    output logic             is_one,
    output logic             rel_zero
);

    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    // Load beats reload, reload beats decrement.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        if (load_ext) begin
            count_d  = load_val;
            reload_d = load_val;
        end else if (load_rel) begin
            count_d  = reload_q;
        end else if (dec) begin
            count_d  = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign count    = count_q;
    assign is_zero  = (count_q == '0);
    assign is_one   = (count_q == WIDTH'(1));
    assign rel_zero = (reload_q == '0);

endmodule : cnt_down4_dp
`default_nettype wire

// File: rtl/cnt_down4.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_down4
//  Description : Loadable down-counter/timer. Parallel-loads a start value,
//                decrements once per enabled clock while running, and emits a
//                registered one-cycle terminal-count pulse.
//                Build option CNT_DOWN4_AUTORELOAD_EN: counter reloads from
//                the last loaded value after reaching zero instead of
//                stopping (periodic mode).
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-low
//                pl    - parallel load strobe (highest priority)
//                in    - load value
//                en    - count enable (only acts in RUN)
//                out   - current count
//                tc    - terminal-count pulse
//                busy  - high while counting state is RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_down4
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pl,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    cnt_state_e state_q, state_d;
    logic       tc_q, tc_d;

    logic w_load_rel;
    logic w_dec;
    logic w_is_zero;
    logic w_is_one;
    logic w_rel_zero;

    cnt_down4_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load_ext (pl),
        .load_val (in),
        .load_rel (w_load_rel),
        .dec      (w_dec),
        .count    (out),
        .is_zero  (w_is_zero),
        .is_one   (w_is_one),
        .rel_zero (w_rel_zero)
    );

`ifdef CNT_DOWN4_AUTORELOAD_EN
    // Periodic mode: DONE is never entered; a zero load still runs and
    // pulses tc on every enabled cycle.
    always_comb begin
        state_d    = state_q;
        tc_d       = 1'b0;
        w_load_rel = 1'b0;
        w_dec      = 1'b0;
        if (pl) begin
            state_d = ST_RUN;
            tc_d    = (in == '0);
        end else if (state_q == ST_RUN && en) begin
            if (w_is_zero) begin
                w_load_rel = 1'b1;
                tc_d       = w_rel_zero;
            end else begin
                w_dec = 1'b1;
                tc_d  = w_is_one;
            end
        end
    end
`else
    // One-shot mode: count stops at zero and parks in DONE.
    logic unused_rel_zero;
    assign unused_rel_zero = w_rel_zero;

    always_comb begin
        state_d    = state_q;
        tc_d       = 1'b0;
        w_load_rel = 1'b0;
        w_dec      = 1'b0;
        if (pl) begin
            if (in == '0) begin
                state_d = ST_DONE;
                tc_d    = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN && en) begin
            // Zero is never seen in RUN here; the guard keeps out from wrapping.
            if (!w_is_zero) begin
                w_dec = 1'b1;
            end
            if (w_is_one || w_is_zero) begin
                tc_d    = w_is_one;
                state_d = ST_DONE;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);

endmodule : cnt_down4
`default_nettype wire

// File: tb/tb_cnt_down4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_down4
//  Description : Self-checking bench for cnt_down4: directed scenarios plus
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_down4;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         pl;
    logic [W-1:0] in;
    logic         en;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;

    int checks = 0;
    int fails  = 0;

    // Behavioural reference: integer count, last loaded value, running flag.
    int m_out;
    int m_rel;
    bit m_run;
    bit m_tc;

    cnt_down4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .pl    (pl),
        .in    (in),
        .en    (en),
        .out   (out),
        .tc    (tc),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0;
        m_rel = 0;
        m_run = 0;
        m_tc  = 0;
    endtask

    // Apply one rising edge of the spec rules to the model.
    task automatic model_edge(input bit p, input int v, input bit e);
        if (p) begin
            m_out = v;
            m_rel = v;
`ifdef CNT_DOWN4_AUTORELOAD_EN
            m_run = 1;
`else
            m_run = (v != 0);
`endif
            m_tc  = (v == 0);
        end else if (m_run && e) begin
`ifdef CNT_DOWN4_AUTORELOAD_EN
            if (m_out == 0) begin
                m_out = m_rel;
                m_tc  = (m_rel == 0);
            end else begin
                m_out = m_out - 1;
                m_tc  = (m_out == 0);
            end
`else
            m_out = m_out - 1;
            m_tc  = (m_out == 0);
            if (m_tc) m_run = 0;
`endif
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},  int'(out),  m_out);
        chk({tag, ".tc"},   int'(tc),   int'(m_tc));
        chk({tag, ".busy"}, int'(busy), int'(m_run));
    endtask

    // One clock: inputs held across the edge, outputs sampled 1 time unit later.
    task automatic cyc(input bit p, input int v, input bit e, input string tag);
        pl = p;
        in = W'(v);
        en = e;
        @(posedge clk);
        model_edge(p, v, e);
        #1;
        check_all(tag);
    endtask

    int ncyc;

    initial begin
        reset = 1'b0;
        pl    = 1'b0;
        in    = '0;
        en    = 1'b0;
        model_reset();
        #10;
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Idle: enable alone changes nothing.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, "idle_en");

        // Load 10, count continuously to expiry, then hold at 0.
        cyc(1, 10, 1, "load10");
        chk("load10.value", int'(out), 10);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, "cnt10");
        chk("pre_expiry.tc", int'(tc), 0);
        cyc(0, 0, 1, "expiry10");
        chk("expiry.tc_pulse", int'(tc), 1);
        chk("expiry.busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, "hold0");

        // Same load, enable toggling each cycle: 10 enabled cycles to expiry.
        cyc(1, 10, 0, "load10b");
        ncyc = 0;
        while (!tc && ncyc < 40) begin
            cyc(0, 0, ncyc[0] == 1'b0, "toggle_en");
            ncyc++;
        end
        chk("toggle.clocks_to_tc", ncyc, 19);

        // Zero load: immediate expiry.
        cyc(1, 0, 1, "load0");
        chk("load0.tc", int'(tc), 1);
        cyc(0, 0, 1, "after_load0");

        // Reload at out=3 with 5: restart without tc.
        cyc(1, 7, 1, "load7");
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, "cnt7");
        chk("at3", int'(out), 3);
        cyc(1, 5, 1, "reload5");
        chk("reload5.out", int'(out), 5);

        // pl held several cycles: reload each edge, no counting.
        for (int i = 0; i < 3; i++) cyc(1, 9, 1, "pl_held");

        // pl coincident with the expiry edge: load wins.
        cyc(1, 2, 1, "load2");
        cyc(0, 0, 1, "cnt2");
        cyc(1, 6, 1, "pl_at_tc");
        chk("pl_at_tc.tc", int'(tc), 0);

        // All-ones load: 15 enabled cycles to expiry.
        cyc(1, 15, 1, "load15");
        ncyc = 0;
        while (!tc && ncyc < 40) begin
            cyc(0, 0, 1, "cnt15");
            ncyc++;
        end
        chk("allones.cycles", ncyc, 15);

        // Asynchronous reset mid-count at out=6.
        cyc(1, 8, 1, "load8");
        cyc(0, 0, 1, "cnt8");
        cyc(0, 0, 1, "cnt8");
        chk("at6", int'(out), 6);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 1, "post_reset_idle");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) == 0, int'($urandom_range(0, 15)),
                ($urandom % 4) != 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_cnt_down4
`default_nettype wire

// File: doc/cnt_down4.md
# cnt_down4

Loadable down-counter/timer for the counter library: parallel-loads a start value, decrements once per enabled clock, and flags terminal count with a one-cycle pulse. It is the counterpart of the loadable up-counter cnt8: same load interface (pl/in/out), opposite count direction, plus a small run-control state machine. Used as a programmable delay/period generator alongside the up-counters.

## Interface
- WIDTH, 4, counter and load width in bits (≥2)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- pl  input  1  parallel load strobe, sampled at rising edge, highest priority
- in  input  WIDTH  load value, used when pl=1
- en  input  1  count enable, ignored outside RUN
- out  output  WIDTH  current count
- tc  output  1  terminal-count pulse, registered, one cycle
- busy  output  1  high while state is RUN

## Operation
- Reset (async, low): out=0, tc=0, busy=0, reload register=0, state=IDLE.
- States: IDLE (after reset), RUN (counting), DONE (expired, one-shot only).
- Edge priority: reset > pl > en.
- pl=1 in any state: out<=in, reload<=in. If in≠0 → RUN, tc<=0. If in=0 → DONE, tc<=1 (immediate expiry).
- RUN, en=1, out>1: out<=out-1, tc<=0.
- RUN, en=1, out=1: out<=0, tc<=1; state → DONE (one-shot).
- RUN, en=0: out, state hold; tc<=0.
- DONE/IDLE: out holds, tc<=0, en ignored; exit only via pl.
- busy = (state==RUN), registered-equivalent (derived from state register).
- No underflow in one-shot: out never wraps below 0.
- Arithmetic modulo 2^WIDTH; load of all-ones yields 2^WIDTH−1 enabled cycles to expiry.

## Timing
- Load latency: out valid one clock after pl edge.
- Expiry: after load of N≠0, tc asserts on the edge of the N-th enabled cycle (same edge out becomes 0); tc high exactly one cycle.
- pl coincident with tc edge: load wins; new count starts, tc=0.
- pl held high multiple cycles: reloads every edge, no counting.
- Reset mid-count: all outputs cleared asynchronously, independent of clk; on release, IDLE.

## Configuration
- Macro CNT_DOWN4_AUTORELOAD_EN.
- Defined: no DONE entry from count. RUN, en=1, out=0 → out<=reload, tc<=0; out=1 → out<=0, tc<=1, stay RUN. Period = N+1 enabled cycles (N..0), tc once per period. reload=0 with pl → state RUN, out stays 0, tc<=1 on every enabled cycle. busy stays high until reset.
- Undefined: one-shot behaviour above; DONE reachable.

## Structure
- Shared package cnt_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant.
- Sub-module cnt_down4_dp: count register, reload register, decrement and zero/one detect; top holds FSM and tc register.

## Test plan
- Reset low at t=0, release after 10 → out=0, tc=0, busy=0, state IDLE; en=1 produces no change.
- pl=1 with in=4'b1010, en=1 → out 10,9,…,1,0 on successive edges; tc high only on edge where out=0; busy drops same edge; out holds 0 thereafter.
- Same load, en toggled 1/0 every cycle → expiry after 10 enabled cycles (≈20 clocks); out holds during en=0.
- pl=1 with in=0 → out=0, tc pulse next edge, state DONE; pl during count at out=3 with in=5 → out=5, count restarts, no tc.
- reset asserted mid-count (out=6) between edges → out=0, busy=0 immediately, before next clk edge.
- With CNT_DOWN4_AUTORELOAD_EN, load 3, en=1 → out 3,2,1,0,3,2,1,0…; tc once per 4 cycles; busy stays 1.
